relu2_seq: RTL

//   Sequencer/initiator for the relu2 activation stage of the CNN datapath.

---
 rtl/relu2_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/relu2_seq.sv
// relu2_seq: sweeps the conv2 result buffer through the relu2 stage one element
// at a time and writes each activation to the pool2 buffer, counting non-zero outputs.
module relu2_seq #(
  parameter int DATA_W  = 30,
  parameter int N_ELEM  = 1600,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   pos_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              relu_enable,
  output logic [DATA_W-1:0] relu_in,
  input  logic [DATA_W-1:0] relu_out,
  input  logic              relu_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_RUN,
    S_WB,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W:0]     pos_cnt_q, pos_cnt_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                relu_enable_q, relu_enable_d;
  logic [DATA_W-1:0]   relu_in_q, relu_in_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      tmo_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      pos_cnt_q     <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      relu_enable_q <= 1'b0;
      relu_in_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      pos_cnt_q     <= pos_cnt_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      relu_enable_q <= relu_enable_d;
      relu_in_q     <= relu_in_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  // Outputs are registered, so each strobe is set on entry to the state that owns it.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    pos_cnt_d     = pos_cnt_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    relu_enable_d = relu_enable_q;
    relu_in_d     = relu_in_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RD;
          idx_d     = '0;
          pos_cnt_d = '0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      S_RD: begin
        state_d = S_RDW;
      end
      S_RDW: begin
        relu_in_d     = rd_data;
        relu_enable_d = 1'b1;
        tmo_d         = '0;
        state_d       = S_RUN;
      end
      S_RUN: begin
        if (relu_done) begin
          wr_data_d     = relu_out;
          wr_addr_d     = idx_q;
          wr_en_d       = 1'b1;
          relu_enable_d = 1'b0;
          if (relu_out != '0) begin
            pos_cnt_d = pos_cnt_q + 1'b1;
          end
          state_d = S_WB;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // Timed-out element is abandoned: no write, idx and pos_cnt frozen.
          error_d       = 1'b1;
          relu_enable_d = 1'b0;
          done_d        = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        if (idx_q == ADDR_W'(N_ELEM - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          idx_d     = idx_q + 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q + 1'b1;
          state_d   = S_RD;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign pos_cnt     = pos_cnt_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign relu_enable = relu_enable_q;
  assign relu_in     = relu_in_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule
